// File: rtl/puf_calib_evaluator.sv
// Calibration evaluator: latches PDL config/challenge, fires the arbiter PUF N_EVALS times, returns the ones-count.
// Optional response timeout is enabled by defining CALIB_TIMEOUT_EN.
module puf_calib_evaluator #(
    parameter int unsigned PDL_CONFIG_WIDTH = 128,
    parameter int unsigned CHALLENGE_WIDTH  = 32,
    parameter int unsigned RESPONSE_WIDTH   = 6,
    parameter int unsigned N_EVALS          = 63,
    parameter int unsigned SETTLE_CYC       = 8,
    parameter int unsigned TIMEOUT_CYC      = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        calb_trigger,
    input  logic [PDL_CONFIG_WIDTH-1:0] pdl_config,
    input  logic [CHALLENGE_WIDTH-1:0]  pc_challenge,
    output logic [PDL_CONFIG_WIDTH-1:0] pdl_cfg_out,
    output logic [CHALLENGE_WIDTH-1:0]  challenge_out,
    output logic                        puf_fire,
    input  logic                        puf_resp_valid,
    input  logic                        puf_resp,
    output logic                        busy,
    output logic                        done,
    output logic [RESPONSE_WIDTH-1:0]   raw_response,
    output logic                        timeout_flag
);

    localparam int unsigned EVAL_W   = $clog2(N_EVALS + 1);
    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYC + 1);
    localparam logic [EVAL_W-1:0]   EVAL_LAST   = EVAL_W'(N_EVALS);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);

    if (N_EVALS < 1 || N_EVALS > (2 ** RESPONSE_WIDTH) - 1 || SETTLE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("puf_calib_evaluator: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_FIRE, S_WAIT, S_FINISH} state_t;

    state_t                      state_q;
    logic [PDL_CONFIG_WIDTH-1:0] pdl_cfg_q;
    logic [CHALLENGE_WIDTH-1:0]  chal_q;
    logic [RESPONSE_WIDTH-1:0]   ones_q, ones_d, raw_q;
    logic [EVAL_W-1:0]           eval_cnt_q, eval_cnt_d;
    logic [SETTLE_W-1:0]         settle_cnt_q;
    logic                        fire_q, busy_q, done_q;
    logic                        resp_take, to_hit, eval_end;

`ifdef CALIB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] wait_cnt_q;
    logic            timeout_q;

    // The fire cycle itself is not part of the timeout window.
    assign to_hit       = (state_q == S_WAIT) && !fire_q && !puf_resp_valid && (wait_cnt_q == TO_LAST);
    assign timeout_flag = timeout_q;
`else
    assign to_hit       = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        resp_take  = (state_q == S_WAIT) && !fire_q && puf_resp_valid;
        eval_end   = resp_take || to_hit;
        eval_cnt_d = eval_cnt_q + 1'b1;
        ones_d     = ones_q;
        if (resp_take && puf_resp && (ones_q != '1)) begin
            ones_d = ones_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pdl_cfg_q    <= '0;
            chal_q       <= '0;
            ones_q       <= '0;
            raw_q        <= '0;
            eval_cnt_q   <= '0;
            settle_cnt_q <= '0;
            fire_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef CALIB_TIMEOUT_EN
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            fire_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (calb_trigger) begin
                        pdl_cfg_q    <= pdl_config;
                        chal_q       <= pc_challenge;
                        ones_q       <= '0;
                        eval_cnt_q   <= '0;
                        settle_cnt_q <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= S_SETTLE;
`ifdef CALIB_TIMEOUT_EN
                        timeout_q    <= 1'b0;
`endif
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_q <= '0;
                        state_q      <= S_FIRE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                S_FIRE: begin
                    fire_q  <= 1'b1;
                    state_q <= S_WAIT;
`ifdef CALIB_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                S_WAIT: begin
`ifdef CALIB_TIMEOUT_EN
                    if (!fire_q && !puf_resp_valid) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                    if (to_hit) begin
                        timeout_q <= 1'b1;
                    end
`endif
                    if (eval_end) begin
                        ones_q     <= ones_d;
                        eval_cnt_q <= eval_cnt_d;
                        state_q    <= (eval_cnt_d == EVAL_LAST) ? S_FINISH : S_SETTLE;
                    end
                end
                S_FINISH: begin
                    raw_q   <= ones_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pdl_cfg_out   = pdl_cfg_q;
    assign challenge_out = chal_q;
    assign puf_fire      = fire_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign raw_response  = raw_q;

endmodule

// File: tb/tb_puf_calib_evaluator.sv
// Directed bench for puf_calib_evaluator; scenario 5 is active when CALIB_TIMEOUT_EN is defined.
module tb_puf_calib_evaluator;

    localparam logic [127:0] CFG_A5   = {16{8'hA5}};
    localparam logic [127:0] CFG_ALT  = {16{8'h3C}};
    localparam logic [31:0]  CHAL     = 32'h1234_5678;
    localparam logic [31:0]  CHAL_ALT = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic         calb_trigger = 1'b0;
    logic [127:0] pdl_config = '0;
    logic [31:0]  pc_challenge = '0;
    logic [127:0] pdl_cfg_out;
    logic [31:0]  challenge_out;
    logic         puf_fire, puf_resp_valid, puf_resp, busy, done, timeout_flag;
    logic [5:0]   raw_response;

    logic m_valid = 1'b0, m_resp = 1'b0, s_valid = 1'b0;
    assign puf_resp_valid = m_valid | s_valid;
    assign puf_resp       = m_valid ? m_resp : s_valid;

    puf_calib_evaluator #(
        .PDL_CONFIG_WIDTH(128), .CHALLENGE_WIDTH(32), .RESPONSE_WIDTH(6),
        .N_EVALS(63), .SETTLE_CYC(8), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .reset(reset), .calb_trigger(calb_trigger),
        .pdl_config(pdl_config), .pc_challenge(pc_challenge),
        .pdl_cfg_out(pdl_cfg_out), .challenge_out(challenge_out),
        .puf_fire(puf_fire), .puf_resp_valid(puf_resp_valid), .puf_resp(puf_resp),
        .busy(busy), .done(done), .raw_response(raw_response), .timeout_flag(timeout_flag)
    );

    logic         trig6 = 1'b0, p6_valid = 1'b0, p6_resp = 1'b0;
    logic [127:0] cfg6 = '0, pdl6;
    logic [31:0]  chal6 = '0, chal6_out;
    logic         fire6, busy6, done6, to6;
    logic [5:0]   raw6;

    puf_calib_evaluator #(
        .PDL_CONFIG_WIDTH(128), .CHALLENGE_WIDTH(32), .RESPONSE_WIDTH(6),
        .N_EVALS(1), .SETTLE_CYC(1), .TIMEOUT_CYC(16)
    ) dut_min (
        .clk(clk), .reset(reset), .calb_trigger(trig6),
        .pdl_config(cfg6), .pc_challenge(chal6),
        .pdl_cfg_out(pdl6), .challenge_out(chal6_out),
        .puf_fire(fire6), .puf_resp_valid(p6_valid), .puf_resp(p6_resp),
        .busy(busy6), .done(done6), .raw_response(raw6), .timeout_flag(to6)
    );

    int n_tests = 0, n_fail = 0;

    // PUF model: answers 3 cycles after each fire; mode 0 = always 1, mode 1 = 1 on every 3rd eval.
    int mode = 0, silent_idx = 0;
    bit stray_en = 1'b0;
    int since = 99, fire_idx = 0;
    always @(negedge clk) begin
        m_valid = 1'b0;
        m_resp  = 1'b0;
        s_valid = 1'b0;
        if (!busy) fire_idx = 0;
        if (reset) since = 99;
        else if (puf_fire) begin
            fire_idx++;
            since = 0;
        end else if (since < 99) since++;
        if (since == 3 && !(silent_idx != 0 && fire_idx == silent_idx)) begin
            m_valid = 1'b1;
            m_resp  = (mode == 0) ? 1'b1 : (fire_idx % 3 == 0);
        end
        if (stray_en && (since == 0 || since == 5)) s_valid = 1'b1;
    end

    logic [127:0] exp_cfg = '0;
    int fire_total = 0, done_total = 0, cfg_bad = 0;
    always @(negedge clk) begin
        if (puf_fire) fire_total++;
        if (done) done_total++;
        if (busy && pdl_cfg_out !== exp_cfg) cfg_bad++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drives one run; optionally re-triggers with other data when the trig2_at-th fire is seen.
    task automatic run_eval(input logic [127:0] cfg, input logic [31:0] chal, input int trig2_at,
                            output int first_fire, output bit got_done);
        int k, nf;
        first_fire = -1;
        got_done   = 1'b0;
        nf         = 0;
        @(negedge clk);
        exp_cfg      = cfg;
        pdl_config   = cfg;
        pc_challenge = chal;
        calb_trigger = 1'b1;
        @(negedge clk);
        calb_trigger = 1'b0;
        pdl_config   = '0;
        pc_challenge = '0;
        k = 1;
        while (k < 3000) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (puf_fire) begin
                nf++;
                if (first_fire < 0) first_fire = k;
            end
            if (trig2_at > 0 && puf_fire && nf == trig2_at) begin
                calb_trigger = 1'b1;
                pdl_config   = CFG_ALT;
                pc_challenge = CHAL_ALT;
            end else begin
                calb_trigger = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        calb_trigger = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, done, puf_fire, timeout_flag, raw_response} !== 10'd0 || pdl_cfg_out !== '0 || challenge_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b fire=%b to=%b raw=%0d cfg=%h chal=%h, required all 0",
                     busy, done, puf_fire, timeout_flag, raw_response, pdl_cfg_out, challenge_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_all_ones;
        int ff, f0, d0;
        bit got;
        mode = 0;
        f0 = fire_total;
        d0 = done_total;
        run_eval(CFG_A5, CHAL, 0, ff, got);
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL t1_done: no done within budget, required done");
            return;
        end
        n_tests++;
        if (raw_response !== 6'd63) begin n_fail++; $display("FAIL t1_raw: got %0d required 63", raw_response); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_at_done: got %b required 0", busy); end
        n_tests++;
        if (ff !== 10) begin n_fail++; $display("FAIL t1_first_fire_latency: got %0d required 10", ff); end
        n_tests++;
        if (challenge_out !== CHAL) begin n_fail++; $display("FAIL t1_challenge: got %h required %h", challenge_out, CHAL); end
        n_tests++;
        if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL t1_timeout_flag: got %b required 0", timeout_flag); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (fire_total - f0 !== 63) begin n_fail++; $display("FAIL t1_fire_count: got %0d required 63", fire_total - f0); end
        n_tests++;
        if (done_total - d0 !== 1) begin n_fail++; $display("FAIL t1_done_count: got %0d required 1", done_total - d0); end
        n_tests++;
        if (busy !== 1'b0 || raw_response !== 6'd63) begin
            n_fail++;
            $display("FAIL t1_after_done: busy=%b raw=%0d required busy=0 raw=63", busy, raw_response);
        end
    endtask

    task automatic test_every_third;
        int ff, c0;
        bit got;
        mode = 1;
        c0 = cfg_bad;
        run_eval(CFG_A5, CHAL, 0, ff, got);
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL t2_done: no done within budget, required done"); return; end
        n_tests++;
        if (raw_response !== 6'd21) begin n_fail++; $display("FAIL t2_raw: got %0d required 21", raw_response); end
        n_tests++;
        if (cfg_bad - c0 !== 0) begin n_fail++; $display("FAIL t2_cfg_stable: %0d cycles with pdl_cfg_out != A5..A5, required 0", cfg_bad - c0); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int ff, c0, f0, d0;
        bit got;
        mode     = 1;
        stray_en = 1'b1;
        c0 = cfg_bad;
        f0 = fire_total;
        d0 = done_total;
        run_eval(CFG_A5, CHAL, 10, ff, got);
        stray_en = 1'b0;
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL t3_done: no done within budget, required done"); return; end
        n_tests++;
        if (raw_response !== 6'd21) begin n_fail++; $display("FAIL t3_raw: got %0d required 21", raw_response); end
        n_tests++;
        if (cfg_bad - c0 !== 0) begin n_fail++; $display("FAIL t3_cfg_stable: %0d bad cycles, required 0", cfg_bad - c0); end
        n_tests++;
        if (challenge_out !== CHAL) begin n_fail++; $display("FAIL t3_challenge: got %h required %h", challenge_out, CHAL); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (fire_total - f0 !== 63 || done_total - d0 !== 1) begin
            n_fail++;
            $display("FAIL t3_counts: fires=%0d dones=%0d required 63 and 1", fire_total - f0, done_total - d0);
        end
    endtask

    task automatic test_reset_midrun;
        int k, nf, d0, ff;
        bit got;
        mode = 0;
        nf   = 0;
        d0   = done_total;
        @(negedge clk);
        exp_cfg      = CFG_A5;
        pdl_config   = CFG_A5;
        pc_challenge = CHAL;
        calb_trigger = 1'b1;
        @(negedge clk);
        calb_trigger = 1'b0;
        k = 0;
        while (nf < 30 && k < 3000) begin
            @(negedge clk);
            k++;
            if (puf_fire) nf++;
        end
        n_tests++;
        if (nf != 30) begin n_fail++; $display("FAIL t4_reach_eval30: saw %0d fires, required 30", nf); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if ({busy, done, puf_fire, timeout_flag, raw_response} !== 10'd0 || pdl_cfg_out !== '0 || challenge_out !== '0) begin
            n_fail++;
            $display("FAIL t4_reset_outputs: busy=%b done=%b fire=%b to=%b raw=%0d cfg=%h chal=%h, required all 0",
                     busy, done, puf_fire, timeout_flag, raw_response, pdl_cfg_out, challenge_out);
        end
        repeat (60) @(negedge clk);
        n_tests++;
        if (done_total - d0 !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_no_done: dones=%0d busy=%b required 0 and 0", done_total - d0, busy);
        end
        run_eval(CFG_ALT, CHAL_ALT, 0, ff, got);
        n_tests++;
        if (!got || raw_response !== 6'd63 || challenge_out !== CHAL_ALT) begin
            n_fail++;
            $display("FAIL t4_rerun: done=%b raw=%0d chal=%h required 1, 63, %h", got, raw_response, challenge_out, CHAL_ALT);
        end
        repeat (3) @(negedge clk);
    endtask

`ifdef CALIB_TIMEOUT_EN
    task automatic test_timeout;
        int ff, d0;
        bit got;
        mode       = 0;
        silent_idx = 5;
        d0 = done_total;
        run_eval(CFG_A5, CHAL, 0, ff, got);
        silent_idx = 0;
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL t5_done: no done within budget, required done"); return; end
        n_tests++;
        if (raw_response !== 6'd62) begin n_fail++; $display("FAIL t5_raw: got %0d required 62", raw_response); end
        n_tests++;
        if (timeout_flag !== 1'b1) begin n_fail++; $display("FAIL t5_timeout_flag: got %b required 1", timeout_flag); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (done_total - d0 !== 1 || timeout_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_after_done: dones=%0d flag=%b required 1 and 1", done_total - d0, timeout_flag);
        end
    endtask
`endif

    // Trigger in cycle T: fire expected in T+3, response in R, done in R+2.
    task automatic test_min_config;
        for (int run = 0; run < 2; run++) begin
            @(negedge clk);
            trig6 = 1'b1;
            cfg6  = (run == 0) ? CFG_ALT : CFG_A5;
            chal6 = (run == 0) ? CHAL_ALT : CHAL;
            @(negedge clk);
            trig6 = 1'b0;
            @(negedge clk);
            @(negedge clk);
            n_tests++;
            if (fire6 !== 1'b1) begin n_fail++; $display("FAIL t6_fire_at_3 run%0d: got %b required 1", run, fire6); end
            if (run == 0) begin
                p6_valid = 1'b1;
                p6_resp  = 1'b1;
                @(negedge clk);
                p6_valid = 1'b0;
                n_tests++;
                if (fire6 !== 1'b0 || done6 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL t6_fire_width_or_early_done: fire=%b done=%b required 0 0", fire6, done6);
                end
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
            p6_valid = 1'b1;
            p6_resp  = (run == 1);
            @(negedge clk);
            p6_valid = 1'b0;
            p6_resp  = 1'b0;
            n_tests++;
            if (done6 !== 1'b0) begin n_fail++; $display("FAIL t6_done_r1 run%0d: got %b required 0", run, done6); end
            @(negedge clk);
            n_tests++;
            if (done6 !== 1'b1 || busy6 !== 1'b0 || raw6 !== ((run == 1) ? 6'd1 : 6'd0)) begin
                n_fail++;
                $display("FAIL t6_done_r2 run%0d: done=%b busy=%b raw=%0d required 1 0 %0d", run, done6, busy6, raw6, run);
            end
            n_tests++;
            if (pdl6 !== cfg6 || chal6_out !== chal6 || to6 !== 1'b0) begin
                n_fail++;
                $display("FAIL t6_latched run%0d: cfg=%h chal=%h to=%b required %h %h 0", run, pdl6, chal6_out, to6, cfg6, chal6);
            end
        end
    endtask

    initial begin
        test_reset;
        test_all_ones;
        test_every_third;
        test_back_to_back;
        test_reset_midrun;
`ifdef CALIB_TIMEOUT_EN
        test_timeout;
`endif
        test_min_config;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
